// File: rtl/display_mux_bcd.sv
// display_mux_bcd: scans three latched BCD digits onto a shared active-low
// 7-segment bus, with optional leading-zero blanking and an invalid-digit flag.
module display_mux_bcd #(
    parameter int DIV_REFRESH  = 50000,
    parameter bit APAGAR_ZEROS = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] U,
    input  logic       Carregar,
    output logic [6:0] Segmentos,
    output logic [2:0] Anodos,
    output logic       Erro
);
    localparam int CW = $clog2(DIV_REFRESH);

    typedef enum logic [1:0] {UNI = 2'd0, DEZ = 2'd1, CEN = 2'd2} idx_t;

    idx_t          idx, idxNext;
    logic [CW-1:0] refreshCnt;
    logic [3:0]    rc, rd, ru, digSel;
    logic [6:0]    segCode;
    logic [2:0]    anSel;
    logic          wrap, blank, idxValid;

    assign wrap     = refreshCnt == CW'(DIV_REFRESH - 1);
    assign idxValid = idx inside {UNI, DEZ, CEN};

    always_ff @(posedge Clock) begin
        if (!Reset_n) idx <= UNI;
        else          idx <= idxNext;
    end

    always_comb begin
        idxNext = idx;
        if (!idxValid)  idxNext = UNI;
        else if (wrap)  idxNext = (idx == UNI) ? DEZ : (idx == DEZ) ? CEN : UNI;
    end

    always_comb begin
        digSel = (idx == CEN) ? rc : (idx == DEZ) ? rd : ru;
        anSel  = (idx == CEN) ? 3'b011 : (idx == DEZ) ? 3'b101 : 3'b110;
        // A zero only blanks when every higher digit is zero too, so a dash is never hidden
        blank  = !idxValid || (APAGAR_ZEROS &&
                 ((idx == CEN && rc == 4'd0) || (idx == DEZ && rc == 4'd0 && rd == 4'd0)));
        case (digSel)
            4'd0:    segCode = 7'h40;
            4'd1:    segCode = 7'h79;
            4'd2:    segCode = 7'h24;
            4'd3:    segCode = 7'h30;
            4'd4:    segCode = 7'h19;
            4'd5:    segCode = 7'h12;
            4'd6:    segCode = 7'h02;
            4'd7:    segCode = 7'h78;
            4'd8:    segCode = 7'h00;
            4'd9:    segCode = 7'h10;
            default: segCode = 7'h3F;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            rc         <= '0;
            rd         <= '0;
            ru         <= '0;
            refreshCnt <= '0;
            Anodos     <= 3'b111;
            Segmentos  <= 7'h7F;
            Erro       <= 1'b0;
        end else begin
            if (Carregar) begin
                rc <= C;
                rd <= D;
                ru <= U;
            end
            refreshCnt <= wrap ? '0 : refreshCnt + 1'b1;
            Anodos     <= blank ? 3'b111 : anSel;
            Segmentos  <= blank ? 7'h7F : segCode;
            Erro       <= (rc > 4'd9) || (rd > 4'd9) || (ru > 4'd9);
        end
    end
endmodule

// File: tb/tb_display_mux_bcd.sv
// tb_display_mux_bcd: directed literal checks plus randomized stimulus compared
// every cycle against a slot-arithmetic model, for blanking on and off.
module tb_display_mux_bcd;
    localparam int DIV = 4;
    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       Clock = 1'b0, Reset_n = 1'b0, Carregar = 1'b0;
    logic [3:0] C = '0, D = '0, U = '0;
    logic [6:0] seg1, seg0;
    logic [2:0] an1, an0;
    logic       err1, err0;

    int         checks = 0, failures = 0;
    logic [3:0] mDig [3];
    int         ticks = 0;
    bit         mValid = 1'b0;
    logic [2:0] eAn1, eAn0;
    logic [6:0] eSeg1, eSeg0;
    logic       eErr;

    always #5 Clock = ~Clock;

    display_mux_bcd #(.DIV_REFRESH(DIV), .APAGAR_ZEROS(1'b1)) dut1 (
        .Clock(Clock), .Reset_n(Reset_n), .C(C), .D(D), .U(U), .Carregar(Carregar),
        .Segmentos(seg1), .Anodos(an1), .Erro(err1));

    display_mux_bcd #(.DIV_REFRESH(DIV), .APAGAR_ZEROS(1'b0)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n), .C(C), .D(D), .U(U), .Carregar(Carregar),
        .Segmentos(seg0), .Anodos(an0), .Erro(err0));

    // Slot number is simply elapsed scan cycles divided by slot length, modulo three digits
    function automatic logic [9:0] modelOut(int t, logic [3:0] c, logic [3:0] d, logic [3:0] u, bit blankEn);
        int         slot = (t / DIV) % 3;
        logic [3:0] v = (slot == 2) ? c : (slot == 1) ? d : u;
        bit         blank = blankEn && ((slot == 2 && c == 0) || (slot == 1 && c == 0 && d == 0));
        return blank ? {3'b111, 7'h7F} : {~(3'b001 << slot), (v > 9) ? 7'h3F : SEG_TBL[v]};
    endfunction

    task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    always @(posedge Clock) begin
        if (!Reset_n) begin
            mDig          <= '{4'd0, 4'd0, 4'd0};
            ticks         <= 0;
            {eAn1, eSeg1} <= {3'b111, 7'h7F};
            {eAn0, eSeg0} <= {3'b111, 7'h7F};
            eErr          <= 1'b0;
            mValid        <= 1'b1;
        end else begin
            {eAn1, eSeg1} <= modelOut(ticks, mDig[2], mDig[1], mDig[0], 1'b1);
            {eAn0, eSeg0} <= modelOut(ticks, mDig[2], mDig[1], mDig[0], 1'b0);
            eErr          <= mDig[0] > 9 || mDig[1] > 9 || mDig[2] > 9;
            ticks         <= ticks + 1;
            if (Carregar) mDig <= '{U, D, C};
        end
    end

    always @(negedge Clock) begin
        if (mValid) begin
            chk("model_an_blank", 7'(an1), 7'(eAn1));
            chk("model_seg_blank", seg1, eSeg1);
            chk("model_err_blank", 7'(err1), 7'(eErr));
            chk("model_an_noblank", 7'(an0), 7'(eAn0));
            chk("model_seg_noblank", seg0, eSeg0);
            chk("model_err_noblank", 7'(err0), 7'(eErr));
        end
    end

    initial begin
        repeat (3) step();
        chk("reset_an", 7'(an1), 7'(3'b111));
        chk("reset_seg", seg1, 7'h7F);
        chk("reset_err", 7'(err1), 7'd0);
        Reset_n = 1'b1;
        step();
        chk("release_an", 7'(an1), 7'(3'b110));
        chk("release_seg", seg1, 7'h40);
        step();
        step();
        Carregar = 1'b1; D = 4'd9;
        step();
        Carregar = 1'b0;
        step();
        chk("wrap_load_an", 7'(an1), 7'(3'b101));
        chk("wrap_load_seg", seg1, 7'h10);
        C = 4'd0; D = 4'd12; U = 4'd3; Carregar = 1'b1;
        step();
        Carregar = 1'b0;
        step();
        chk("bad_digit_err", 7'(err1), 7'd1);
        chk("bad_digit_an", 7'(an1), 7'(3'b101));
        chk("bad_digit_dash", seg1, 7'h3F);
        C = 4'd1; D = 4'd0; U = 4'd0; Carregar = 1'b1;
        step();
        Carregar = 1'b0;
        step();
        chk("hundred_err", 7'(err1), 7'd0);
        chk("hundred_an", 7'(an1), 7'(3'b011));
        chk("hundred_seg", seg1, 7'h79);
        repeat (8) step();
        chk("inner_zero_an", 7'(an1), 7'(3'b101));
        chk("inner_zero_seg", seg1, 7'h40);
        repeat (3) step();
        C = 4'd0; D = 4'd0; U = 4'd7; Carregar = 1'b1;
        step();
        Carregar = 1'b0;
        step();
        chk("blank_cen_an", 7'(an1), 7'(3'b111));
        chk("blank_cen_seg", seg1, 7'h7F);
        chk("noblank_cen_an", 7'(an0), 7'(3'b011));
        chk("noblank_cen_seg", seg0, 7'h40);
        Reset_n = 1'b0; Carregar = 1'b1; C = 4'd5; D = 4'd5; U = 4'd5;
        step();
        chk("midscan_reset_an", 7'(an1), 7'(3'b111));
        chk("midscan_reset_seg", seg1, 7'h7F);
        Reset_n = 1'b1; Carregar = 1'b0;
        step();
        chk("after_reset_an", 7'(an1), 7'(3'b110));
        chk("after_reset_seg", seg1, 7'h40);
        chk("after_reset_seg_noblank", seg0, 7'h40);
        for (int i = 0; i < 3000; i++) begin
            Reset_n  = $urandom_range(0, 199) != 0;
            Carregar = $urandom_range(0, 3) == 0;
            C = ($urandom_range(0, 2) == 0) ? 4'd0 : ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            D = ($urandom_range(0, 2) == 0) ? 4'd0 : ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            U = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_mux_bcd.md
DISPLAY_MUX_BCD -- requirements
Module: display_mux_bcd

Interface
REQ-001 Parameter DIV_REFRESH, default 50000: the number of clock cycles each digit stays selected. Legal range is 2 to 2^20.
REQ-002 Parameter APAGAR_ZEROS, default 1: when set to 1, leading-zero blanking is enabled.
REQ-003 Port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port C, input, 4 bits: hundreds (centena) BCD digit from the upstream binary-to-BCD converter.
REQ-006 Port D, input, 4 bits: tens (dezena) BCD digit.
REQ-007 Port U, input, 4 bits: units (unidade) BCD digit.
REQ-008 Port Carregar, input, 1 bit: load strobe; C, D and U are captured on every edge where it is 1.
REQ-009 Port Segmentos, output, 7 bits: segment pattern, active-low, bit order [6:0] = g f e d c b a.
REQ-010 Port Anodos, output, 3 bits: digit enables, active-low; [0] = units, [1] = tens, [2] = hundreds.
REQ-011 Port Erro, output, 1 bit: high while any latched digit is greater than 9.

Function
REQ-012 The block shall hold three 4-bit digit registers (RC, RD, RU), a refresh counter, and a 2-bit digit index IDX with states UNI=0, DEZ=1, CEN=2.
REQ-013 When Carregar=1 and Reset_n=1, RC/RD/RU shall take C/D/U at that edge; otherwise they hold their value.
REQ-014 The refresh counter shall count 0 to DIV_REFRESH-1 and wrap to 0. IDX shall advance on the edge where the counter wraps.
REQ-015 IDX shall follow the sequence UNI -> DEZ -> CEN -> UNI; the value 3 is unreachable and, if ever present, shall return to UNI on the next edge.
REQ-016 Anodos and Segmentos shall be registered and computed from the current IDX and digit registers, giving exactly 1 cycle of latency after any change in IDX or in the digit registers.
REQ-017 Exactly one Anodos bit shall be 0 at a time (the one selected by IDX), except when that digit is blanked, in which case Anodos=3'b111 and Segmentos=7'h7F.
REQ-018 Blanking rules when APAGAR_ZEROS=1:
  - CEN is blanked when RC=0.
  - DEZ is blanked when RC=0 and RD=0.
  - UNI is never blanked.
  When APAGAR_ZEROS=0, no digit is ever blanked.
REQ-019 Segment encoding, hex values:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A digit value of 10 to 15 shall display a dash, 3F.
REQ-020 A digit value greater than 9 is never blanked, even where the blanking conditions would otherwise apply.
REQ-021 Erro shall be registered: it is 1 on the cycle after the digit registers hold any value greater than 9, and 0 otherwise.
REQ-022 When Carregar coincides with a counter wrap, both the load and the IDX advance shall take effect at the same edge; the output on the following cycle uses the new data and the new IDX.
REQ-023 When Carregar is held at 1 continuously, the digit registers shall track C/D/U every cycle; the refresh timing is unaffected.
REQ-024 The refresh counter width shall be ceil(log2(DIV_REFRESH)) bits, and no overflow beyond DIV_REFRESH-1 shall occur.

Reset
REQ-025 On an edge with Reset_n=0, the following shall take these values:
  - RC = RD = RU = 0
  - refresh counter = 0
  - IDX = UNI
  - Anodos = 3'b111
  - Segmentos = 7'h7F
  - Erro = 0
REQ-026 Reset has priority over Carregar. Asserting reset mid-scan shall abort the scan, and operation resumes from UNI with count 0 on the first edge with Reset_n=1.
REQ-027 On the first edge after reset is released, the outputs shall become Anodos=3'b110 and Segmentos=7'h40 (units showing "0").

Verification (run with DIV_REFRESH=4)
REQ-028 Reset release followed by 12 idle cycles -> Anodos=110 with Segmentos=40. CEN and DEZ are blanked (Anodos=111, Segmentos=7F) in their 4-cycle slots. Slot order is UNI, DEZ, CEN, with 4 cycles per slot.
REQ-029 Load C=2, D=5, U=5 (value 255), then scan -> UNI slot shows 12, DEZ slot shows 12, CEN slot shows 24, with Anodos 110/101/011 respectively and Erro=0.
REQ-030 Load C=0, D=0, U=7, then scan -> UNI shows 78 and the DEZ and CEN slots are blanked. With APAGAR_ZEROS=0, the same stimulus gives DEZ=40 and CEN=40.
REQ-031 Load C=0, D=12, U=3 -> Erro=1 one cycle after the load, and the DEZ slot shows 3F (not blanked). A subsequent load of C=1, D=0, U=0 -> Erro=0, and DEZ shows 40 (not blanked because RC is non-zero).
REQ-032 Carregar asserted on the counter-wrap edge from UNI to DEZ with D=9 -> the next cycle shows Anodos=101 and Segmentos=10.
REQ-033 Reset_n pulsed low during the CEN slot while Carregar=1 -> the digit registers read 0, and the first edge after release gives Anodos=110 and Segmentos=40.
